// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable parameterised RAM.
// Holds the clear FSM state encoding and the per-byte even-parity function.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Even parity: the stored bit makes the total number of ones in byte+bit even.
  function automatic logic byteParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Full-memory clear sequencer: walks a counter across every word address,
// issuing an all-zero write each cycle while holding busy high.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clr_req_i,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              clr_we_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The counter saturates at the last address; DONE gives one idle cycle before re-arming.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          count_d = '0;
        end
      end
      CLEAR: begin
        if (count_q == LAST_ADDR) state_d = DONE;
        else                      count_d = count_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr_addr_o = count_q;
  assign clr_we_o   = (state_q == CLEAR);
  assign busy_o     = (state_q == CLEAR);

endmodule

// File: rtl/ram_param_clr.sv
// Byte-enabled single-port RAM with registered read data and a hardware full clear.
// Optional per-byte even parity storage and checking when RAM_PARITY_EN is defined.
module ram_param_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic                clock,
  input  logic                aclr_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] byteena,
  input  logic                rden,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                busy,
  output logic                parity_err
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clrAddr;
  logic              clrWe;
  logic              accept;
  logic              doWrite;
  logic [DATA_W-1:0] rdWord;
  logic [DATA_W-1:0] mergedWord;
  logic              parMismatch;

  logic [DATA_W-1:0] q_q;
  logic              qValid_q;
  logic              parErr_q;

  ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .clr_req_i  (clr_req),
    .clr_addr_o (clrAddr),
    .clr_we_o   (clrWe),
    .busy_o     (busy)
  );

  assign accept  = !busy && (wren || rden);
  assign doWrite = accept && wren && (|byteena);

  // The read path returns the word as it will look after this cycle's write.
  always_comb begin
    rdWord     = mem[address];
    mergedWord = rdWord;
    for (int b = 0; b < NB; b++) begin
      if (wren && byteena[b]) mergedWord[b*8 +: 8] = data[b*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (clrWe)        mem[clrAddr] <= '0;
    else if (doWrite) mem[address] <= mergedWord;
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rdPar;
  logic [NB-1:0] mergedPar;

  // Written bytes take fresh parity; untouched bytes are checked against what was stored.
  always_comb begin
    rdPar       = par[address];
    mergedPar   = rdPar;
    parMismatch = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (wren && byteena[b]) mergedPar[b] = byteParity(data[b*8 +: 8]);
      if (byteParity(mergedWord[b*8 +: 8]) != mergedPar[b]) parMismatch = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clrWe)        par[clrAddr] <= '0;
    else if (doWrite) par[address] <= mergedPar;
  end
`else
  assign parMismatch = 1'b0;
`endif

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      q_q      <= '0;
      qValid_q <= 1'b0;
      parErr_q <= 1'b0;
    end else begin
      qValid_q <= accept;
      parErr_q <= accept && parMismatch;
      if (accept) q_q <= mergedWord;
    end
  end

  assign q          = q_q;
  assign q_valid    = qValid_q;
  assign parity_err = parErr_q;

endmodule

// File: doc/ram_param_clr.md
RAM_PARAM_CLR -- requirements
Module: ram_param_clr

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning data word width in bits, a multiple of 8, minimum 8.
REQ-002 The module SHALL have parameter ADDR_W, default 14, meaning address width, with depth DEPTH = 2**ADDR_W words.
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port aclr_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port address, input, ADDR_W bits, word address for read/write.
REQ-006 The module SHALL have port data, input, DATA_W bits, write data.
REQ-007 The module SHALL have port wren, input, 1 bit, write request.
REQ-008 The module SHALL have port byteena, input, DATA_W/8 bits, per-byte write enable; bit i covers data[8i+7:8i].
REQ-009 The module SHALL have port rden, input, 1 bit, read request.
REQ-010 The module SHALL have port clr_req, input, 1 bit, single-cycle pulse starting a full-memory clear.
REQ-011 The module SHALL have port q, output, DATA_W bits, registered read data.
REQ-012 The module SHALL have port q_valid, output, 1 bit, one-cycle pulse qualifying q.
REQ-013 The module SHALL have port busy, output, 1 bit, high while a clear is in progress.
REQ-014 The module SHALL have port parity_err, output, 1 bit, one-cycle pulse aligned with q_valid on parity mismatch.

Function
REQ-015 An access SHALL be accepted on a rising edge with busy=0 and wren=1 or rden=1.
REQ-016 A write SHALL update only the bytes whose byteena bit is 1; all other bytes keep their old value.
REQ-017 q and q_valid SHALL follow an accepted access by exactly 1 cycle; q is the word at address after the write is applied, so byteena-merged new data appears on a write.
REQ-018 Outside q_valid cycles, q SHALL hold its last value.
REQ-019 A write with byteena = 0 SHALL act as a read.
REQ-020 The clear FSM SHALL have states IDLE, CLEAR and DONE, and SHALL start in IDLE.
REQ-021 In IDLE, clr_req=1 SHALL move the FSM to CLEAR, reset the clear counter to 0 and set busy=1 on the next cycle.
REQ-022 In CLEAR, each cycle SHALL write all-zero data with all bytes enabled at the counter address, then increment the counter.
REQ-023 When the counter reaches DEPTH-1, that write SHALL complete and the FSM SHALL go to DONE.
REQ-024 In DONE, busy SHALL be low and the FSM SHALL go to IDLE after one cycle; a clear takes DEPTH cycles of busy=1.
REQ-025 While busy=1, wren, rden and clr_req SHALL be ignored, with no queuing.
REQ-026 If clr_req arrives on the same edge as an access in IDLE, the access SHALL complete and the clear SHALL start on that same edge.
REQ-027 The clear counter SHALL be ADDR_W bits wide and SHALL not wrap past DEPTH-1.

Reset
REQ-028 aclr_n=0 SHALL asynchronously force FSM to IDLE, clear counter to 0, q=0, q_valid=0, busy=0 and parity_err=0.
REQ-029 Memory contents SHALL not be reset by aclr_n.
REQ-030 A reset during CLEAR SHALL abort the clear, leaving contents partially cleared and unspecified, and SHALL not auto-restart it.
REQ-031 The first access SHALL be accepted on the first rising edge after aclr_n deasserts.

Configuration
REQ-032 When RAM_PARITY_EN is defined, the RAM SHALL store one even-parity bit per byte, computed at write (including clear writes), checked on every read, and pulse parity_err with q_valid on any byte mismatch.
REQ-033 When RAM_PARITY_EN is undefined, no parity storage SHALL exist and parity_err SHALL be constant 0.

Structure
REQ-034 Package ram_pkg SHALL hold the clear FSM state enum (clr_state_t) and a byte-parity function.
REQ-035 Sub-module ram_clear_fsm SHALL contain the FSM and counter and SHALL supply clear address, write strobe and busy to the top level; the array stays in ram_param_clr.

Verification
REQ-036 Reset, then write 16'hA5A5 at 14'h0010 with byteena=2'b11, then read 14'h0010 -> q=16'hA5A5 with q_valid one cycle after each access.
REQ-037 Byte lanes: write 16'h1234 at 14'h0020, then write 16'hFFFF with byteena=2'b01 -> q=16'h12FF; then byteena=2'b00 -> q=16'h12FF.
REQ-038 Clear with ADDR_W=4: fill addr 0..15 with its address, pulse clr_req -> busy high exactly 16 cycles; rden during busy -> no q_valid; all reads afterwards -> 16'h0000.
REQ-039 Reset mid-clear with ADDR_W=4: assert aclr_n=0 at cycle 5 of CLEAR -> busy=0, q=0, q_valid=0 immediately; addr 0..3 read 0; no restart.
REQ-040 Concurrent clr_req and write in IDLE at 14'h0003 with 16'hBEEF -> q=16'hBEEF next cycle, busy=1, and a later read of 14'h0003 -> 0.
REQ-041 With RAM_PARITY_EN, read back REQ-036..038 data -> parity_err=0; a forced bit flip in the stored byte -> parity_err=1 with q_valid.
